// File: rtl/spi_obi_bridge.sv
// SPI mode-0 target that turns each SPI frame into one single-word OBI manager transaction.
// SPI pins are oversampled in the clk_i domain; no logic is clocked by SCLK.
module spi_obi_bridge #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    spi_ss_i,
    input  logic                    spi_sclk_i,
    input  logic                    spi_mosi_i,
    output logic                    spi_miso_o,
    output logic                    spi_miso_oe_o,
    output logic                    obi_req_o,
    input  logic                    obi_gnt_i,
    output logic [ADDR_WIDTH-1:0]   obi_addr_o,
    output logic                    obi_we_o,
    output logic [DATA_WIDTH/8-1:0] obi_be_o,
    output logic [DATA_WIDTH-1:0]   obi_wdata_o,
    input  logic                    obi_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   obi_rdata_i,
    output logic                    rd_late_o,
    output logic                    drop_o
);
    typedef enum logic [1:0] {O_IDLE, O_REQ, O_RESP} obi_state_e;

    localparam logic [5:0] LAST_BIT  = 6'd48;
    localparam logic [5:0] CMD_BIT   = 6'd7;
    localparam logic [5:0] WR_BIT    = 6'd39;
    localparam logic [5:0] LOAD_BIT  = 6'd16;

    logic [1:0]            ss_sync_q, sclk_sync_q, mosi_sync_q;
    logic                  ss_prev_q, sclk_prev_q;
    logic [5:0]            cnt_q;
    logic [DATA_WIDTH-2:0] rx_q, tx_q;
    logic [7:0]            cmd_q;
    logic                  miso_q, rd_late_q, drop_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic                  rd_ready_q, rd_own_q;
    obi_state_e            state_q, state_d;

    logic                  active, ss_fall, sclk_rise, sclk_fall;
    logic [DATA_WIDTH-1:0] rx_next;
    logic [6:0]            offset;
    logic                  issue_rd, issue_wr, issue_req, obi_idle;

    assign active    = ~ss_sync_q[1];
    assign ss_fall   = ss_prev_q & ~ss_sync_q[1];
    assign sclk_rise = active & sclk_sync_q[1] & ~sclk_prev_q;
    assign sclk_fall = active & ~sclk_sync_q[1] & sclk_prev_q;
    assign rx_next   = {rx_q, mosi_sync_q[1]};
    // The first command bit sits in rx_q[6] when the 8th rise arrives.
    assign issue_rd  = sclk_rise && !ss_fall && cnt_q == CMD_BIT && !rx_q[6];
    assign issue_wr  = sclk_rise && !ss_fall && cnt_q == WR_BIT && cmd_q[7];
    assign issue_req = issue_rd | issue_wr;
    assign offset    = issue_rd ? rx_next[6:0] : cmd_q[6:0];
    assign obi_idle  = state_q == O_IDLE;

    assign spi_miso_o    = miso_q;
    assign spi_miso_oe_o = active;
    assign obi_addr_o    = addr_q;
    assign obi_we_o      = we_q;
    assign obi_be_o      = '1;
    assign obi_wdata_o   = wdata_q;
    assign rd_late_o     = rd_late_q;
    assign drop_o        = drop_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ss_sync_q   <= 2'b11;
            sclk_sync_q <= 2'b00;
            mosi_sync_q <= 2'b00;
            ss_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
        end else begin
            ss_sync_q   <= {ss_sync_q[0], spi_ss_i};
            sclk_sync_q <= {sclk_sync_q[0], spi_sclk_i};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi_i};
            ss_prev_q   <= ss_sync_q[1];
            sclk_prev_q <= sclk_sync_q[1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            cmd_q     <= '0;
            miso_q    <= 1'b0;
            rd_late_q <= 1'b0;
        end else begin
            rd_late_q <= 1'b0;
            if (!active) begin
                cnt_q  <= '0;
                miso_q <= 1'b0;
            end else if (ss_fall) begin
                cnt_q  <= '0;
                rx_q   <= '0;
                miso_q <= 1'b0;
            end else begin
                if (sclk_rise && cnt_q != LAST_BIT) begin
                    cnt_q <= cnt_q + 6'd1;
                    rx_q  <= rx_next[DATA_WIDTH-2:0];
                    if (cnt_q == CMD_BIT) cmd_q <= rx_next[7:0];
                end
                if (sclk_fall) begin
                    if (cmd_q[7] || cnt_q < LOAD_BIT || cnt_q == LAST_BIT) begin
                        miso_q <= 1'b0;
                    end else if (cnt_q == LOAD_BIT) begin
                        tx_q      <= rd_ready_q ? rdata_q[DATA_WIDTH-2:0] : '1;
                        miso_q    <= rd_ready_q ? rdata_q[DATA_WIDTH-1] : 1'b1;
                        rd_late_q <= ~rd_ready_q;
                    end else begin
                        tx_q   <= {tx_q[DATA_WIDTH-3:0], 1'b0};
                        miso_q <= tx_q[DATA_WIDTH-2];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= O_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            O_IDLE:  if (issue_req)    state_d = O_REQ;
            O_REQ:   if (obi_gnt_i)    state_d = O_RESP;
            O_RESP:  if (obi_rvalid_i) state_d = O_IDLE;
            default:                   state_d = O_IDLE;
        endcase
    end

    always_comb begin
        obi_req_o = (state_q == O_REQ);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rd_ready_q <= 1'b0;
            rd_own_q   <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            drop_q <= issue_req & ~obi_idle;
            if (issue_req && obi_idle) begin
                addr_q   <= BASE_ADDR + ADDR_WIDTH'({offset, 2'b00});
                we_q     <= issue_wr;
                rd_own_q <= issue_rd;
                if (issue_wr) wdata_q <= rx_next;
            end
            if (state_q == O_RESP && obi_rvalid_i && !we_q) begin
                rd_own_q <= 1'b0;
                if (rd_own_q && active) begin
                    rd_ready_q <= 1'b1;
                    rdata_q    <= obi_rdata_i;
                end
            end
            // NOTE: later non-blocking assignments win, so these clears override the capture above.
            if (issue_rd) rd_ready_q <= 1'b0;
            if (!active) begin
                rd_ready_q <= 1'b0;
                rd_own_q   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_obi_bridge.sv
// Directed bench for spi_obi_bridge: an SPI master drives frames, an OBI slave model answers,
// and expected OBI transactions are queued at stimulus time and compared at the grant.
module tb_spi_obi_bridge;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int          HALF = 6;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } txn_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        spi_ss_i = 1'b1, spi_sclk_i = 1'b0, spi_mosi_i = 1'b0;
    logic        spi_miso_o, spi_miso_oe_o;
    logic        obi_req_o, obi_gnt_i = 1'b0, obi_we_o;
    logic [31:0] obi_addr_o, obi_wdata_o, obi_rdata_i = '0;
    logic [3:0]  obi_be_o;
    logic        obi_rvalid_i = 1'b0;
    logic        rd_late_o, drop_o;

    int   n_checks = 0, n_errors = 0;
    int   n_grants = 0, n_late = 0, n_drop = 0, n_req_cyc = 0;
    int   gnt_delay = 0, rv_delay = 0, gnt_wait = 0, rv_cnt = 0, req_cnt = 0;
    bit   rv_pend = 1'b0, unstable = 1'b0;
    logic [31:0] slave_rdata = '0, snap_addr, snap_wdata;
    logic        snap_we;
    txn_t exp_q[$];

    spi_obi_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .spi_ss_i(spi_ss_i), .spi_sclk_i(spi_sclk_i), .spi_mosi_i(spi_mosi_i),
        .spi_miso_o(spi_miso_o), .spi_miso_oe_o(spi_miso_oe_o),
        .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
        .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
        .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i),
        .rd_late_o(rd_late_o), .drop_o(drop_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // OBI slave model: grants after gnt_delay stalled cycles, answers rv_delay cycles after the first post-grant cycle.
    always @(negedge clk_i) begin
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b0;
        if (rst_i) begin
            rv_pend  = 1'b0;
            gnt_wait = 0;
            req_cnt  = 0;
        end else begin
            if (rv_pend) begin
                if (rv_cnt == 0) begin
                    obi_rvalid_i = 1'b1;
                    obi_rdata_i  = slave_rdata;
                    rv_pend      = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end
            if (obi_req_o) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    snap_addr  = obi_addr_o;
                    snap_we    = obi_we_o;
                    snap_wdata = obi_wdata_o;
                    unstable   = 1'b0;
                end else if (obi_addr_o !== snap_addr || obi_we_o !== snap_we || obi_wdata_o !== snap_wdata) begin
                    unstable = 1'b1;
                end
                if (gnt_wait >= gnt_delay) begin
                    txn_t e;
                    obi_gnt_i = 1'b1;
                    n_grants++;
                    rv_pend = 1'b1;
                    rv_cnt  = rv_delay;
                    check("txn_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("txn_addr", obi_addr_o, e.addr);
                        check("txn_we", obi_we_o, e.we);
                        if (e.we) check("txn_wdata", obi_wdata_o, e.wdata);
                        check("txn_be", obi_be_o, 4'hF);
                    end
                    check("req_hold", req_cnt, gnt_delay + 1);
                    check("req_stable", unstable, 0);
                    gnt_wait = 0;
                    req_cnt  = 0;
                end else begin
                    gnt_wait++;
                end
            end else begin
                gnt_wait = 0;
                req_cnt  = 0;
            end
        end
    end

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (rd_late_o) n_late++;
            if (drop_o)    n_drop++;
            if (obi_req_o) n_req_cyc++;
        end
    end

    task automatic spi_xfer(input logic [47:0] tx, input int nbits, output logic [47:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi_i = tx[47-i];
            repeat (HALF) @(negedge clk_i);
            spi_sclk_i = 1'b1;
            rx[47-i]   = spi_miso_o;
            repeat (HALF) @(negedge clk_i);
            spi_sclk_i = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [47:0] tx, input int nbits, output logic [47:0] rx);
        spi_ss_i = 1'b0;
        repeat (HALF) @(negedge clk_i);
        spi_xfer(tx, nbits, rx);
        repeat (HALF) @(negedge clk_i);
        spi_ss_i = 1'b1;
        repeat (4) @(negedge clk_i);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] rx;
        int g0, l0, rc0, waited;

        repeat (3) @(negedge clk_i);
        check("rst_miso", spi_miso_o, 0);
        check("rst_miso_oe", spi_miso_oe_o, 0);
        check("rst_req", obi_req_o, 0);
        check("rst_we", obi_we_o, 0);
        check("rst_addr", obi_addr_o, 0);
        check("rst_wdata", obi_wdata_o, 0);
        check("rst_be", obi_be_o, 4'hF);
        check("rst_rd_late", rd_late_o, 0);
        check("rst_drop", drop_o, 0);
        rst_i = 1'b0;
        repeat (4) @(negedge clk_i);

        // Write with immediate grant and response.
        exp_q.push_back('{BASE + 32'h14, 1'b1, 32'hDEAD_BEEF});
        g0 = n_grants;
        spi_frame({8'h85, 32'hDEAD_BEEF, 8'h00}, 40, rx);
        repeat (20) @(negedge clk_i);
        check("wr_grants", n_grants - g0, 1);
        check("wr_miso_zero", rx, 0);

        // Read, data returned 2 cycles after the grant.
        rv_delay = 1;
        slave_rdata = 32'hA5A5_0F0F;
        exp_q.push_back('{BASE + 32'h0C, 1'b0, 32'h0});
        g0 = n_grants;
        l0 = n_late;
        spi_frame({8'h03, 40'h0}, 48, rx);
        repeat (10) @(negedge clk_i);
        check("rd_grants", n_grants - g0, 1);
        check("rd_head_zero", rx[47:32], 0);
        check("rd_data", rx[31:0], 32'hA5A5_0F0F);
        check("rd_not_late", n_late - l0, 0);

        // Write with a 20-cycle grant stall.
        gnt_delay = 20;
        rv_delay  = 0;
        exp_q.push_back('{BASE + 32'h28, 1'b1, 32'h1357_9BDF});
        g0  = n_grants;
        rc0 = n_req_cyc;
        spi_frame({8'h8A, 32'h1357_9BDF, 8'h00}, 40, rx);
        repeat (40) @(negedge clk_i);
        check("stall_grants", n_grants - g0, 1);
        check("stall_req_cycles", n_req_cyc - rc0, 21);

        // Read whose data comes back after the load point.
        gnt_delay   = 0;
        rv_delay    = 150;
        slave_rdata = 32'h0F0F_A5A5;
        exp_q.push_back('{BASE + 32'h44, 1'b0, 32'h0});
        l0 = n_late;
        spi_frame({8'h11, 40'h0}, 48, rx);
        repeat (20) @(negedge clk_i);
        check("late_data", rx[31:0], 32'hFFFF_FFFF);
        check("late_pulses", n_late - l0, 1);

        // Write aborted after 20 bits, then a normal read.
        rv_delay = 0;
        g0  = n_grants;
        rc0 = n_req_cyc;
        spi_ss_i = 1'b0;
        repeat (HALF) @(negedge clk_i);
        spi_xfer({8'h85, 32'hCAFE_F00D, 8'h00}, 20, rx);
        repeat (HALF) @(negedge clk_i);
        spi_ss_i = 1'b1;
        @(posedge clk_i); #1;
        check("abort_oe_hold", spi_miso_oe_o, 1);
        @(posedge clk_i); #1;
        check("abort_oe_fall", spi_miso_oe_o, 0);
        repeat (60) @(negedge clk_i);
        check("abort_no_req", n_req_cyc - rc0, 0);
        check("abort_no_grant", n_grants - g0, 0);
        slave_rdata = 32'h1234_5678;
        exp_q.push_back('{BASE + 32'h1FC, 1'b0, 32'h0});
        spi_frame({8'h7F, 40'h0}, 48, rx);
        repeat (10) @(negedge clk_i);
        check("post_abort_rd", rx[31:0], 32'h1234_5678);

        // Reset while the request is stalled in O_REQ.
        gnt_delay = 1000;
        exp_q.push_back('{BASE + 32'h08, 1'b1, 32'h2468_ACE0});
        spi_ss_i = 1'b0;
        repeat (HALF) @(negedge clk_i);
        spi_xfer({8'h82, 32'h2468_ACE0, 8'h00}, 40, rx);
        waited = 0;
        while (!obi_req_o && waited < 100) begin
            @(negedge clk_i);
            waited++;
        end
        check("rst_req_seen", obi_req_o, 1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        check("midrst_req", obi_req_o, 0);
        check("midrst_oe", spi_miso_oe_o, 0);
        repeat (2) @(negedge clk_i);
        rst_i     = 1'b0;
        spi_ss_i  = 1'b1;
        gnt_delay = 0;
        exp_q.delete();
        repeat (10) @(negedge clk_i);
        exp_q.push_back('{BASE + 32'h04, 1'b1, 32'h0BAD_F00D});
        g0 = n_grants;
        spi_frame({8'h81, 32'h0BAD_F00D, 8'h00}, 40, rx);
        repeat (20) @(negedge clk_i);
        check("post_rst_grants", n_grants - g0, 1);

        check("queue_drained", exp_q.size(), 0);
        check("no_drops", n_drop, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
